// File: rtl/timer_dev.sv
// timer_dev: memory-mapped down-counter with interrupt for the mips data bus.
// Registers (word offsets): 0 = CTRL {IM, MODE[1:0], EN}, 1 = PRESET, 2 = COUNT (read-only), 3 = reserved.
// Optional build macro TIMER_BYTE_WRITE_EN: honour byteen per byte on CTRL/PRESET writes.
// Without it, any write with byteen != 0 writes the whole word and byteen == 0 is no write.
// The bus is a plain strobe interface: a write is a single cycle with we=1, there is no
// valid/ready handshake; reads are combinational from addr.
module timer_dev #(
    parameter logic [31:0] RESET_PRESET = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [3:0]  ctrl, ctrl_next;
    logic [31:0] preset, preset_next;
    logic [31:0] count, count_next;
    logic        irq_flag, flag_next;

    logic        ctrl_wr;
    logic        preset_wr;
    logic [3:0]  ctrl_wdata;
    logic [31:0] preset_wdata;

    // Only the register select bits of the word address are decoded.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^addr[29:2];

    // Bus write decode: which register is written and with what merged value.
    always_comb begin
        ctrl_wr      = 1'b0;
        preset_wr    = 1'b0;
        ctrl_wdata   = wdata[3:0];
        preset_wdata = wdata;
`ifdef TIMER_BYTE_WRITE_EN
        ctrl_wr   = we && (addr[1:0] == 2'd0) && byteen[0];
        preset_wr = we && (addr[1:0] == 2'd1) && (byteen != 4'b0000);
        for (int i = 0; i < 4; i++) begin
            preset_wdata[8*i +: 8] = byteen[i] ? wdata[8*i +: 8] : preset[8*i +: 8];
        end
`else
        ctrl_wr   = we && (addr[1:0] == 2'd0) && (byteen != 4'b0000);
        preset_wr = we && (addr[1:0] == 2'd1) && (byteen != 4'b0000);
`endif
    end

    // Next-state logic: FSM step first, then bus writes override (bus write wins).
    always_comb begin
        state_next  = state;
        ctrl_next   = ctrl;
        preset_next = preset;
        count_next  = count;
        flag_next   = irq_flag;

        case (state)
            IDLE: begin
                if (ctrl[0]) state_next = LOAD;
            end
            LOAD: begin
                count_next = preset;
                flag_next  = 1'b0;
                state_next = CNT;
            end
            CNT: begin
                if (!ctrl[0]) begin
                    state_next = IDLE;
                end else if (count > 32'd1) begin
                    count_next = count - 32'd1;
                end else begin
                    // PRESET of 0 or 1 both land here: no wrap below zero.
                    count_next = 32'd0;
                    flag_next  = 1'b1;
                    state_next = INT;
                end
            end
            INT: begin
                if (ctrl[2:1] == 2'b01) begin
                    state_next = LOAD;
                end else begin
                    ctrl_next[0] = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (ctrl_wr) begin
            ctrl_next = ctrl_wdata;
            flag_next = 1'b0;
        end
        if (preset_wr) preset_next = preset_wdata;
    end

    // State and register update with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ctrl     <= 4'd0;
            preset   <= RESET_PRESET;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_next;
            ctrl     <= ctrl_next;
            preset   <= preset_next;
            count    <= count_next;
            irq_flag <= flag_next;
        end
    end

    // Combinational register read; reserved offset reads zero.
    always_comb begin
        rdata = 32'd0;
        case (addr[1:0])
            2'd0:    rdata = {28'd0, ctrl};
            2'd1:    rdata = preset;
            2'd2:    rdata = count;
            default: rdata = 32'd0;
        endcase
    end

    assign irq       = irq_flag & ctrl[3];
    assign dbg_state = state;

endmodule
